param_stack: RTL and testbench



---
 rtl/param_stack.sv | 127 ++++++++++++
 tb/tb_param_stack.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// Parametrised operand stack: WIDTH x DEPTH entries, eight stack operations,
// zero-latency top/next-of-stack reads and sticky overflow/underflow flags.
module param_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_err,
    output logic [WIDTH-1:0] qtop,
    output logic [WIDTH-1:0] qnext,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_DUP     = 3'd4,
        OP_SWAP    = 3'd5,
        OP_OVER    = 3'd6,
        OP_CLEAR   = 3'd7
    } op_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [CW-1:0]    cnt_m1, cnt_m2;
    logic [AW-1:0]    top_idx, nxt_idx, wr_addr;
    logic [WIDTH-1:0] top_w, nxt_w, wr_data;
    logic             wr_en, swap_en;
    logic [1:0]       need_ops;
    logic             need_space, lack_ops, lack_space;

    assign cnt_m1  = count_q - CW'(1);
    assign cnt_m2  = count_q - CW'(2);
    assign top_idx = cnt_m1[AW-1:0];
    assign nxt_idx = cnt_m2[AW-1:0];
    assign top_w   = mem_q[top_idx];
    assign nxt_w   = mem_q[nxt_idx];

    // NOTE: every signal written in this block gets a default first, so no latches are inferred.
    always_comb begin
        need_ops   = 2'd0;
        need_space = 1'b0;
        case (op_e'(op))
            OP_PUSH:                   need_space = 1'b1;
            OP_POP, OP_REPLACE:        need_ops   = 2'd1;
            OP_DUP:    begin need_ops = 2'd1; need_space = 1'b1; end
            OP_SWAP:                   need_ops   = 2'd2;
            OP_OVER:   begin need_ops = 2'd2; need_space = 1'b1; end
            default:   ;
        endcase

        // Missing operands take precedence over missing space.
        lack_ops   = count_q < CW'(need_ops);
        lack_space = !lack_ops && need_space && (count_q == DEPTH_C);

        count_d = count_q;
        wr_en   = 1'b0;
        swap_en = 1'b0;
        wr_addr = count_q[AW-1:0];
        wr_data = d;
        if (!lack_ops && !lack_space) begin
            case (op_e'(op))
                OP_PUSH:    begin wr_en = 1'b1; count_d = count_q + CW'(1); end
                OP_POP:     count_d = cnt_m1;
                OP_REPLACE: begin wr_en = 1'b1; wr_addr = top_idx; end
                OP_DUP:     begin wr_en = 1'b1; wr_data = top_w; count_d = count_q + CW'(1); end
                OP_SWAP:    swap_en = 1'b1;
                OP_OVER:    begin wr_en = 1'b1; wr_data = nxt_w; count_d = count_q + CW'(1); end
                OP_CLEAR:   count_d = '0;
                default:    ;
            endcase
        end

        ovf_d = (ovf_q && !clr_err) || lack_space;
        unf_d = (unf_q && !clr_err) || lack_ops;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the array is deliberately not reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            if (swap_en) begin
                mem_q[top_idx] <= nxt_w;
                mem_q[nxt_idx] <= top_w;
            end
        end
    end

    assign qtop      = (count_q != '0)      ? top_w : '0;
    assign qnext     = (count_q >= CW'(2))  ? nxt_w : '0;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: default 16x16 instance plus an 8x4 instance.
module tb_param_stack;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                           DUP = 3'd4, SWAP = 3'd5, OVER = 3'd6, CLR = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 16x16 instance
    logic        a_reset = 1'b1, a_clr = 1'b0;
    logic [2:0]  a_op = NOP;
    logic [15:0] a_d = '0, a_qtop, a_qnext;
    logic [4:0]  a_count;
    logic        a_empty, a_full, a_ovf, a_unf;

    param_stack u_a (
        .clk(clk), .reset(a_reset), .op(a_op), .d(a_d), .clr_err(a_clr),
        .qtop(a_qtop), .qnext(a_qnext), .count(a_count), .empty(a_empty),
        .full(a_full), .overflow(a_ovf), .underflow(a_unf)
    );

    // 8x4 instance
    logic        b_reset = 1'b1, b_clr = 1'b0;
    logic [2:0]  b_op = NOP;
    logic [7:0]  b_d = '0, b_qtop, b_qnext;
    logic [2:0]  b_count;
    logic        b_empty, b_full, b_ovf, b_unf;

    param_stack #(.WIDTH(8), .DEPTH(4)) u_b (
        .clk(clk), .reset(b_reset), .op(b_op), .d(b_d), .clr_err(b_clr),
        .qtop(b_qtop), .qnext(b_qnext), .count(b_count), .empty(b_empty),
        .full(b_full), .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One edge per call; outputs are sampled 1 time unit after the edge.
    task automatic step_a(input logic [2:0] op, input logic [15:0] d, input logic clr);
        a_op = op; a_d = d; a_clr = clr;
        @(posedge clk); #1;
        a_op = NOP; a_clr = 1'b0;
    endtask

    task automatic step_b(input logic [2:0] op, input logic [7:0] d, input logic clr);
        b_op = op; b_d = d; b_clr = clr;
        @(posedge clk); #1;
        b_op = NOP; b_clr = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        a_reset = 1'b0; b_reset = 1'b0;
        check("a_rst_count", a_count, 0);
        check("a_rst_empty", a_empty, 1);
        check("a_rst_full",  a_full, 0);
        check("a_rst_qtop",  a_qtop, 0);
        check("a_rst_qnext", a_qnext, 0);
        check("a_rst_flags", {a_ovf, a_unf}, 0);

        // ---------------- basic push / swap / over / replace ----------------
        step_a(PUSH, 16'h1111, 0);
        check("a_p1_qtop",  a_qtop, 16'h1111);
        check("a_p1_qnext", a_qnext, 0);
        step_a(PUSH, 16'h2222, 0);
        step_a(PUSH, 16'h3333, 0);
        check("a_p3_count", a_count, 3);
        check("a_p3_qtop",  a_qtop, 16'h3333);
        check("a_p3_qnext", a_qnext, 16'h2222);
        check("a_p3_empty", a_empty, 0);
        check("a_p3_flags", {a_ovf, a_unf}, 0);
        step_a(SWAP, 16'h0, 0);
        check("a_swap_qtop",  a_qtop, 16'h2222);
        check("a_swap_qnext", a_qnext, 16'h3333);
        check("a_swap_count", a_count, 3);
        step_a(OVER, 16'h0, 0);
        check("a_over_count", a_count, 4);
        check("a_over_qtop",  a_qtop, 16'h3333);
        check("a_over_qnext", a_qnext, 16'h2222);
        step_a(REPL, 16'hABCD, 0);
        check("a_repl_qtop",  a_qtop, 16'hABCD);
        check("a_repl_count", a_count, 4);
        check("a_repl_qnext", a_qnext, 16'h2222);
        step_a(DUP, 16'h0, 0);
        check("a_dup_qtop",  a_qtop, 16'hABCD);
        check("a_dup_qnext", a_qnext, 16'hABCD);
        check("a_dup_count", a_count, 5);

        // ---------------- fill, overflow, drain ----------------
        step_a(CLR, 16'h0, 0);
        check("a_clr_count", a_count, 0);
        check("a_clr_qtop",  a_qtop, 0);
        for (int i = 0; i < 16; i++) step_a(PUSH, 16'h1000 + 16'(i), 0);
        check("a_full_flag",  a_full, 1);
        check("a_full_count", a_count, 16);
        check("a_full_qtop",  a_qtop, 16'h100F);
        check("a_full_ovf",   a_ovf, 0);
        step_a(PUSH, 16'hDEAD, 0);
        check("a_ovf_flag",  a_ovf, 1);
        check("a_ovf_unf",   a_unf, 0);
        check("a_ovf_count", a_count, 16);
        check("a_ovf_qtop",  a_qtop, 16'h100F);
        step_a(OVER, 16'h0, 0);
        check("a_over_full_count", a_count, 16);
        check("a_over_full_unf",   a_unf, 0);
        step_a(NOP, 16'h0, 1);
        check("a_clrerr_flags", {a_ovf, a_unf}, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("a_pop_qtop%0d", i), a_qtop, 16'h100F - 16'(i));
            step_a(POP, 16'h0, 0);
        end
        check("a_drain_empty", a_empty, 1);
        check("a_drain_qtop",  a_qtop, 0);
        check("a_drain_flags", {a_ovf, a_unf}, 0);

        // ---------------- underflow cases ----------------
        step_a(POP, 16'h0, 0);
        check("a_unf_pop_flags", {a_ovf, a_unf}, 2'b01);
        check("a_unf_pop_count", a_count, 0);
        step_a(PUSH, 16'h0055, 0);
        step_a(SWAP, 16'h0, 0);
        check("a_unf_swap_count", a_count, 1);
        check("a_unf_swap_qtop",  a_qtop, 16'h0055);
        check("a_unf_swap_qnext", a_qnext, 0);
        step_a(POP, 16'h0, 0);
        step_a(DUP, 16'h0, 0);
        check("a_unf_dup_flags", {a_ovf, a_unf}, 2'b01);
        check("a_unf_dup_count", a_count, 0);

        // PUSH right after POP reuses the same slot
        step_a(PUSH, 16'h0AAA, 0);
        step_a(POP, 16'h0, 0);
        step_a(PUSH, 16'h0BBB, 0);
        check("a_reuse_qtop",  a_qtop, 16'h0BBB);
        check("a_reuse_count", a_count, 1);

        // ---------------- clr_err coinciding with a new error ----------------
        for (int i = 1; i < 16; i++) step_a(PUSH, 16'h2000 + 16'(i), 0);
        check("a_refill_full", a_full, 1);
        check("a_refill_unf",  a_unf, 1);
        step_a(PUSH, 16'hBEEF, 1);
        check("a_coinc_flags", {a_ovf, a_unf}, 2'b10);
        check("a_coinc_qtop",  a_qtop, 16'h200F);
        step_a(NOP, 16'h0, 1);
        check("a_coinc_clear", {a_ovf, a_unf}, 0);

        // ---------------- CLEAR keeps flags; reset discards the op ----------------
        step_a(CLR, 16'h0, 0);
        step_a(POP, 16'h0, 0);
        for (int i = 0; i < 5; i++) step_a(PUSH, 16'h3000 + 16'(i), 0);
        check("a_p5_count", a_count, 5);
        step_a(CLR, 16'h0, 0);
        check("a_clr5_count", a_count, 0);
        check("a_clr5_flags", {a_ovf, a_unf}, 2'b01);
        for (int i = 0; i < 3; i++) step_a(PUSH, 16'h4000 + 16'(i), 0);
        a_reset = 1'b1;
        step_a(PUSH, 16'h7777, 1);
        a_reset = 1'b0;
        check("a_rst2_count", a_count, 0);
        check("a_rst2_qtop",  a_qtop, 0);
        check("a_rst2_empty", a_empty, 1);
        check("a_rst2_flags", {a_ovf, a_unf}, 0);

        // ---------------- 8x4 instance ----------------
        check("b_rst_count", b_count, 0);
        check("b_rst_empty", b_empty, 1);
        step_b(DUP, 8'h0, 0);
        check("b_dup0_flags", {b_ovf, b_unf}, 2'b01);
        step_b(NOP, 8'h0, 1);
        for (int i = 1; i <= 4; i++) step_b(PUSH, 8'(i * 8'h11), 0);
        check("b_full",      b_full, 1);
        check("b_count4",    b_count, 4);
        check("b_qtop4",     b_qtop, 8'h44);
        check("b_qnext4",    b_qnext, 8'h33);
        step_b(PUSH, 8'hEE, 0);
        check("b_ovf_flags", {b_ovf, b_unf}, 2'b10);
        check("b_ovf_qtop",  b_qtop, 8'h44);
        check("b_ovf_count", b_count, 4);
        step_b(NOP, 8'h0, 1);
        step_b(DUP, 8'h0, 0);
        check("b_dupfull_flags", {b_ovf, b_unf}, 2'b10);
        step_b(SWAP, 8'h0, 0);
        check("b_swap_qtop",  b_qtop, 8'h33);
        check("b_swap_qnext", b_qnext, 8'h44);
        step_b(POP, 8'h0, 0);
        check("b_pop_qtop", b_qtop, 8'h44);
        step_b(POP, 8'h0, 0);
        step_b(POP, 8'h0, 0);
        check("b_pop3_count", b_count, 1);
        check("b_pop3_qtop",  b_qtop, 8'h11);
        check("b_pop3_qnext", b_qnext, 0);
        step_b(CLR, 8'h0, 0);
        check("b_clr_count", b_count, 0);
        check("b_clr_flags", {b_ovf, b_unf}, 2'b10);
        for (int i = 0; i < 3; i++) step_b(PUSH, 8'hA0 + 8'(i), 0);
        check("b_p3_qtop", b_qtop, 8'hA2);
        b_reset = 1'b1;
        step_b(PUSH, 8'h77, 0);
        b_reset = 1'b0;
        check("b_rst2_count", b_count, 0);
        check("b_rst2_qtop",  b_qtop, 0);
        check("b_rst2_flags", {b_ovf, b_unf}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
